// File: rtl/enc_defines.sv
// Shared encoder definitions used by the deblocking neighbour-buffer controller.
package enc_defines;

    localparam int         DB_NB_WORD_W = 28;
    localparam int         DB_NB_ADDR_W = 9;
    localparam logic [6:0] DB_MB_X_MAX  = 7'd119;

    typedef enum logic [2:0] {
        NB_IDLE,
        NB_RD,
        NB_RDW,
        NB_WR,
        NB_DONE
    } nb_state_e;

    // A macroblock column is legal when it lies inside the 120-MB-wide frame.
    function automatic logic mb_x_legal(input logic [6:0] mb_x);
        return (mb_x <= DB_MB_X_MAX);
    endfunction

endpackage

// File: rtl/db_nb_buf_ctrl.sv
// Deblocking upper-neighbour buffer controller: for each MB, fetches the four
// bottom-row 4x4 info words of the MB above from a single-port line RAM, then
// overwrites the same four RAM words with the current MB's bottom row.
module db_nb_buf_ctrl
    import enc_defines::*;
#(
    parameter int WORD_W = DB_NB_WORD_W,
    parameter int ADDR_W = DB_NB_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [6:0]            mb_x_i,
    input  logic [6:0]            mb_y_i,
    input  logic [4*WORD_W-1:0]   cur_info_i,
    output logic [4*WORD_W-1:0]   top_info_o,
    output logic                  top_avail_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  ram_cen_o,
    output logic                  ram_wen_o,
    output logic                  ram_oen_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [WORD_W-1:0]     ram_data_o,
    input  logic [WORD_W-1:0]     ram_data_i
);

    nb_state_e                 state_q, state_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [6:0]                mb_x_q;
    logic [6:0]                mb_y_q;
    logic [3:0][WORD_W-1:0]    cur_q;
    logic [3:0][WORD_W-1:0]    top_q;
    logic                      avail_q;
    logic                      done_q;
    logic                      err_q;

    logic                      accept;
    logic                      reject;
    logic                      cap_en;
    logic [1:0]                cap_idx;
    logic [ADDR_W-1:0]         base_addr;

    // Four consecutive words per MB column: base = mb_x * 4.
    assign base_addr   = ADDR_W'({mb_x_q, 2'b00});

    assign top_info_o  = top_q;
    assign top_avail_o = avail_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != NB_IDLE);

    // Next-state, word counter, RAM strobes and read-capture control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        reject     = 1'b0;
        cap_en     = 1'b0;
        cap_idx    = cnt_q - 2'd1;
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_oen_o  = 1'b1;
        ram_addr_o = '0;
        ram_data_o = '0;

        case (state_q)
            NB_IDLE: begin
                if (start_i) begin
                    if (mb_x_legal(mb_x_i)) begin
                        accept  = 1'b1;
                        cnt_d   = 2'd0;
                        state_d = (mb_y_i != 7'd0) ? NB_RD : NB_WR;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            NB_RD: begin
                ram_cen_o  = 1'b0;
                ram_oen_o  = 1'b0;
                ram_addr_o = base_addr + ADDR_W'(cnt_q);
                // Read data lags the address by one cycle, so word cnt-1 lands now.
                cap_en     = (cnt_q != 2'd0);
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = NB_RDW;
                end
            end
            NB_RDW: begin
                // Drain cycle: the RAM is deselected but its output still
                // presents the last read word.
                ram_oen_o = 1'b0;
                cap_en    = 1'b1;
                cap_idx   = 2'd3;
                cnt_d     = 2'd0;
                state_d   = NB_WR;
            end
            NB_WR: begin
                ram_cen_o  = 1'b0;
                ram_wen_o  = 1'b0;
                ram_addr_o = base_addr + ADDR_W'(cnt_q);
                ram_data_o = cur_q[cnt_q];
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = NB_DONE;
                end
            end
            NB_DONE: begin
                state_d = NB_IDLE;
            end
            default: begin
                state_d = NB_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State register and word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NB_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the accepted request's position and bottom-row info.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mb_x_q <= '0;
            mb_y_q <= '0;
            cur_q  <= '0;
        end else if (accept) begin
            mb_x_q <= mb_x_i;
            mb_y_q <= mb_y_i;
            cur_q  <= cur_info_i;
        end
    end

    // Upper-neighbour result: cleared on a new request, filled from RAM reads,
    // flagged available once a top-row-less MB is ruled out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q   <= '0;
            avail_q <= 1'b0;
        end else if (accept) begin
            top_q   <= '0;
            avail_q <= 1'b0;
        end else begin
            if (cap_en) begin
                top_q[cap_idx] <= ram_data_i;
            end
            if ((state_d == NB_DONE) && (mb_y_q != 7'd0)) begin
                avail_q <= 1'b1;
            end
        end
    end

    // Registered completion and rejection pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state_d == NB_DONE);
            err_q  <= reject;
        end
    end

endmodule

// File: tb/tb_db_nb_buf_ctrl.sv
// Directed bench for db_nb_buf_ctrl with a behavioural single-port RAM.
module tb_db_nb_buf_ctrl;

    localparam int W = 28;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [6:0]        mb_x_i;
    logic [6:0]        mb_y_i;
    logic [4*W-1:0]    cur_info_i;
    logic [4*W-1:0]    top_info_o;
    logic              top_avail_o;
    logic              done_o;
    logic              err_o;
    logic              busy_o;
    logic              ram_cen_o;
    logic              ram_wen_o;
    logic              ram_oen_o;
    logic [8:0]        ram_addr_o;
    logic [W-1:0]      ram_data_o;
    logic [W-1:0]      ram_data_i;

    logic [W-1:0]      mem [512];

    int n_vec = 0;
    int n_bad = 0;

    db_nb_buf_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .mb_x_i     (mb_x_i),
        .mb_y_i     (mb_y_i),
        .cur_info_i (cur_info_i),
        .top_info_o (top_info_o),
        .top_avail_o(top_avail_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .ram_cen_o  (ram_cen_o),
        .ram_wen_o  (ram_wen_o),
        .ram_oen_o  (ram_oen_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i)
    );

    always #5 clk = ~clk;

    // Single-port RAM model: synchronous write, registered read.
    always @(posedge clk) begin
        if (!ram_cen_o && !ram_wen_o)
            mem[ram_addr_o] <= ram_data_o;
        if (!ram_cen_o && !ram_oen_o && ram_wen_o)
            ram_data_i <= mem[ram_addr_o];
    end

    typedef struct {
        logic [6:0]     mb_x;
        logic [6:0]     mb_y;
        logic [4*W-1:0] cur;
        int             exp_err;
        int             exp_done;
        int             exp_avail;
        logic [4*W-1:0] exp_top;
        int             exp_lo;
        int             exp_hi;
    } vec_t;

    vec_t tbl [7];

    function automatic logic [4*W-1:0] pack4(input logic [W-1:0] b);
        return {b + 28'd3, b + 28'd2, b + 28'd1, b};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [6:0] x, input logic [6:0] y, input logic [4*W-1:0] cur,
                         input int inj_at,
                         output int done_cyc, output int done_cnt, output int err_cnt,
                         output int acc_cnt, output int lo, output int hi, output int busy_seen);
        done_cyc = 0; done_cnt = 0; err_cnt = 0; acc_cnt = 0;
        lo = 9999; hi = -1; busy_seen = 0;
        @(negedge clk);
        start_i = 1'b1; mb_x_i = x; mb_y_i = y; cur_info_i = cur;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            start_i = (c == inj_at);
            if (c == inj_at) begin
                mb_x_i = 7'd4; mb_y_i = 7'd0; cur_info_i = {4{28'hEEEEEEE}};
            end
            if (done_o) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
            if (err_o) err_cnt++;
            if (busy_o) busy_seen = 1;
            if (!ram_cen_o) begin
                acc_cnt++;
                if (int'(ram_addr_o) < lo) lo = int'(ram_addr_o);
                if (int'(ram_addr_o) > hi) hi = int'(ram_addr_o);
            end
        end
        start_i = 1'b0;
    endtask

    task automatic run_tbl(input int i);
        int dc, dn, ec, ac, lo, hi, bs;
        apply(tbl[i].mb_x, tbl[i].mb_y, tbl[i].cur, 0, dc, dn, ec, ac, lo, hi, bs);
        chk($sformatf("v%0d err_cnt", i), ec, tbl[i].exp_err);
        chk($sformatf("v%0d done_cycle", i), dc, tbl[i].exp_done);
        chk($sformatf("v%0d done_cnt", i), dn, (tbl[i].exp_done != 0) ? 1 : 0);
        chk($sformatf("v%0d top_avail", i), top_avail_o, tbl[i].exp_avail);
        chk($sformatf("v%0d top_info", i), top_info_o, tbl[i].exp_top);
        if (tbl[i].exp_lo < 0) begin
            chk($sformatf("v%0d ram_accesses", i), ac, 0);
            chk($sformatf("v%0d busy_seen", i), bs, 0);
        end else begin
            chk($sformatf("v%0d addr_lo", i), lo, tbl[i].exp_lo);
            chk($sformatf("v%0d addr_hi", i), hi, tbl[i].exp_hi);
            chk($sformatf("v%0d ram_accesses", i), ac, (tbl[i].exp_done == 10) ? 8 : 4);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d mem[%0d]", i, tbl[i].exp_lo + k),
                    mem[tbl[i].exp_lo + k], tbl[i].cur[k*W +: W]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"},  busy_o, 0);
        chk({tag, " done"},  done_o, 0);
        chk({tag, " err"},   err_o, 0);
        chk({tag, " cen"},   ram_cen_o, 1);
        chk({tag, " wen"},   ram_wen_o, 1);
        chk({tag, " oen"},   ram_oen_o, 1);
        chk({tag, " addr"},  ram_addr_o, 0);
        chk({tag, " wdata"}, ram_data_o, 0);
        chk({tag, " top"},   top_info_o, 0);
        chk({tag, " avail"}, top_avail_o, 0);
    endtask

    initial begin
        int dc, dn, ec, ac, lo, hi, bs;

        //            x       y      cur                    err done avail top                    lo   hi
        tbl[0] = '{7'd0,   7'd0, pack4(28'hA000000), 0, 5,  0, '0,                   0,   3};
        tbl[1] = '{7'd0,   7'd1, pack4(28'hB000000), 0, 10, 1, pack4(28'hA000000),   0,   3};
        tbl[2] = '{7'd119, 7'd5, pack4(28'hC000000), 0, 10, 1, pack4(28'h5A5A500),   476, 479};
        tbl[3] = '{7'd120, 7'd3, pack4(28'h7000000), 1, 0,  1, pack4(28'h5A5A500),   -1,  -1};
        tbl[4] = '{7'd119, 7'd0, pack4(28'hD000000), 0, 5,  0, '0,                   476, 479};
        tbl[5] = '{7'd119, 7'd7, pack4(28'hE000000), 0, 10, 1, pack4(28'hD000000),   476, 479};
        tbl[6] = '{7'd0,   7'd3, pack4(28'hF000000), 0, 10, 1, pack4(28'hB000000),   0,   3};

        for (int a = 0; a < 512; a++) mem[a] = '0;
        for (int k = 0; k < 4; k++) mem[476 + k] = 28'h5A5A500 + 28'(k);
        ram_data_i = '0;

        rst_n = 1'b0; start_i = 1'b0; mb_x_i = '0; mb_y_i = '0; cur_info_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_tbl(i);

        // Second start during WR must be ignored.
        apply(7'd3, 7'd0, pack4(28'h6000000), 2, dc, dn, ec, ac, lo, hi, bs);
        chk("wr_ignore done_cnt", dn, 1);
        chk("wr_ignore done_cycle", dc, 5);
        chk("wr_ignore err_cnt", ec, 0);
        chk("wr_ignore ram_accesses", ac, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("wr_ignore mem[%0d]", 12 + k), mem[12 + k], 28'h6000000 + 28'(k));
        chk("wr_ignore mem[16]", mem[16], 0);

        // Asynchronous reset in the middle of a read burst.
        @(negedge clk);
        start_i = 1'b1; mb_x_i = 7'd0; mb_y_i = 7'd2; cur_info_i = pack4(28'h1110000);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_rd cen", ram_cen_o, 0);
        chk("mid_rd addr", ram_addr_o, 2);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rd_rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_tbl(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
